// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pkg
//  Description : Shared types and constants for the EX/MEM pipeline boundary.
//                State encoding of the two-entry skid buffer and the packed
//                layout of one buffered instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

    // Default field widths; the buffer's DATA_W / REG_ADDR_W default to these
    // so the packed entry layout and the port widths line up.
    localparam int EM_DATA_W     = 32;
    localparam int EM_REG_ADDR_W = 5;

    // Encoding equals the number of entries held, so occupancy decodes trivially.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // One buffered instruction, stored bit-exact.
    typedef struct packed {
        logic [EM_DATA_W-1:0]     alu_result;
        logic [EM_DATA_W-1:0]     store_data;
        logic [EM_REG_ADDR_W-1:0] rd_addr;
        logic                     reg_write;
        logic                     mem_to_reg;
        logic                     mem_read;
        logic                     mem_write;
    } ex_mem_entry_t;

    // Build an entry from the EX stage fields. A write to x0 is architecturally
    // a no-op, so the register-write enable is dropped at capture time.
    function automatic ex_mem_entry_t make_entry(
        input logic [EM_DATA_W-1:0]     alu_result,
        input logic [EM_DATA_W-1:0]     store_data,
        input logic [EM_REG_ADDR_W-1:0] rd_addr,
        input logic                     reg_write,
        input logic                     mem_to_reg,
        input logic                     mem_read,
        input logic                     mem_write
    );
        ex_mem_entry_t e;
        e.alu_result = alu_result;
        e.store_data = store_data;
        e.rd_addr    = rd_addr;
        e.reg_write  = reg_write & (rd_addr != '0);
        e.mem_to_reg = mem_to_reg;
        e.mem_read   = mem_read;
        e.mem_write  = mem_write;
        return e;
    endfunction

    // Clear the control bits of an entry while keeping its data fields, so a
    // killed entry can never cause a register or memory write.
    function automatic ex_mem_entry_t kill_entry(input ex_mem_entry_t e);
        ex_mem_entry_t k;
        k            = e;
        k.reg_write  = 1'b0;
        k.mem_to_reg = 1'b0;
        k.mem_read   = 1'b0;
        k.mem_write  = 1'b0;
        return k;
    endfunction

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_skid_buffer
//  Description : EX/MEM pipeline register built as a two-entry skid buffer.
//                The main entry drives the memory stage; the skid entry
//                catches the instruction already in flight when the memory
//                stage stalls. Ready/valid are decoded from state only, so
//                there is no combinational path from out_ready_i to
//                in_ready_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid_buffer
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = EM_DATA_W,
    parameter int REG_ADDR_W = EM_REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    // EX side
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    // MEM side
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [DATA_W-1:0]     store_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            occupancy_o
);

    logic [1:0]    r_state;
    ex_mem_entry_t r_main;
    ex_mem_entry_t r_skid;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_pop;
    ex_mem_entry_t w_new_entry;

    // Handshake decode: ready/valid depend on the state register alone.
    always_comb begin
        w_in_ready  = (r_state != ST_TWO);
        w_out_valid = (r_state != ST_EMPTY);
        w_accept    = in_valid_i & w_in_ready;
        w_pop       = w_out_valid & out_ready_i;
        w_new_entry = make_entry(alu_result_i, store_data_i, rd_addr_i,
                                 reg_write_i, mem_to_reg_i, mem_read_i,
                                 mem_write_i);
    end

    // State machine and entry storage; flush outranks every handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
            r_main  <= kill_entry(r_main);
            r_skid  <= kill_entry(r_skid);
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_new_entry;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        // Head leaves and the newcomer takes its place.
                        r_main <= w_new_entry;
                    end else if (w_accept) begin
                        r_skid  <= w_new_entry;
                        r_state <= ST_TWO;
                    end else if (w_pop) begin
                        // Main keeps its data so the data outputs hold.
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty buffer.
                    r_state <= ST_EMPTY;
                    r_main  <= kill_entry(r_main);
                    r_skid  <= kill_entry(r_skid);
                end
            endcase
        end
    end

    // Output decode: control bits are masked while nothing is valid, data holds.
    always_comb begin
        in_ready_o   = w_in_ready;
        out_valid_o  = w_out_valid;
        alu_result_o = r_main.alu_result;
        store_data_o = r_main.store_data;
        rd_addr_o    = r_main.rd_addr;
        reg_write_o  = r_main.reg_write  & w_out_valid;
        mem_to_reg_o = r_main.mem_to_reg & w_out_valid;
        mem_read_o   = r_main.mem_read   & w_out_valid;
        mem_write_o  = r_main.mem_write  & w_out_valid;
        case (r_state)
            ST_ONE:  occupancy_o = 2'd1;
            ST_TWO:  occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

endmodule : ex_mem_skid_buffer
`default_nettype wire

// File: doc/ex_mem_skid_buffer.md
Name: ex_mem_skid_buffer

Overview:
- EX/MEM pipeline boundary directly downstream of the ALU.
- Captures the ALU result, store data, destination register and memory/writeback control bits.
- Presents them to the memory stage through a valid/ready handshake.
- Two-entry skid buffer, so a multi-cycle memory access (cache miss) back-pressures EX without dropping an in-flight instruction and without a combinational ready path.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_ADDR_W, 5, width of destination register index

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
flush_i  input  1  synchronous kill of all buffered entries (branch mispredict / exception)
in_valid_i  input  1  EX stage presents an instruction
in_ready_o  output  1  buffer can accept this cycle
alu_result_i  input  DATA_W  ALU data output (address for LW/SW, result otherwise)
store_data_i  input  DATA_W  rs2 value (forwarded) for SW
rd_addr_i  input  REG_ADDR_W  destination register
reg_write_i  input  1  instruction writes register file
mem_to_reg_i  input  1  writeback selects memory data
mem_read_i  input  1  load
mem_write_i  input  1  store
out_valid_o  output  1  main entry valid
out_ready_i  input  1  memory stage consumes main entry this cycle
alu_result_o  output  DATA_W  main entry result
store_data_o  output  DATA_W  main entry store data
rd_addr_o  output  REG_ADDR_W  main entry rd
reg_write_o  output  1  gated by out_valid_o
mem_to_reg_o  output  1  gated by out_valid_o
mem_read_o  output  1  gated by out_valid_o
mem_write_o  output  1  gated by out_valid_o
occupancy_o  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State register: EMPTY, ONE, TWO.
- Decode from state only, no input-to-output combinational path:
  - in_ready_o = (state != TWO)
  - out_valid_o = (state != EMPTY)
  - occupancy_o = 0 / 1 / 2 for EMPTY / ONE / TWO
- Handshake definitions:
  - accept = in_valid_i & in_ready_o
  - pop = out_valid_o & out_ready_i
- Transitions:
  - EMPTY: accept -> ONE, capture into main.
  - ONE: accept & pop -> ONE, main overwritten with new input. accept & !pop -> TWO, capture into skid. !accept & pop -> EMPTY. Neither -> hold.
  - TWO: pop -> ONE, skid copied to main, skid cleared. No accept is possible (in_ready_o=0).
- Latency: data accepted in cycle N appears on outputs in cycle N+1 when the buffer was EMPTY, or when it was ONE and pop occurred.
- Ordering: strict FIFO; skid content never bypasses main.
- x0 rule: on capture, stored reg_write = reg_write_i & (rd_addr_i != 0).
- Control gating: reg_write_o, mem_to_reg_o, mem_read_o and mem_write_o are 0 whenever out_valid_o=0.
- Data outputs: alu_result_o, store_data_o and rd_addr_o hold the last main value when invalid.
- Flush:
  - flush_i=1 -> next state EMPTY.
  - Both entries' stored control bits cleared.
  - Any simultaneous accept is discarded.
  - Flush has priority over accept and pop.
- Reset (async, rst_i=1), all immediate:
  - State EMPTY, all entry registers 0.
  - Outputs: out_valid_o=0, in_ready_o=1, occupancy_o=0, all data/control outputs 0.
  - Reset mid-transfer discards both entries.
- Width: no arithmetic; fields stored bit-exact. MUL/SRAI results pass unchanged.

Decomposition:
- Shared package ex_mem_pkg:
  - State encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Packed entry typedef ex_mem_entry_t: alu_result, store_data, rd_addr, reg_write, mem_to_reg, mem_read, mem_write.
- No sub-module. Both entries are instances of the typedef inside this module; the state machine is small enough to stay inline.

Test Plan:
- Reset: assert rst_i mid-cycle with state TWO -> immediately out_valid_o=0, in_ready_o=1, occupancy_o=0, mem_write_o=0.
- Single pass-through: out_ready_i=1; present alu_result=32'h0000_0040, rd=5, reg_write=1, mem_read=1, mem_to_reg=1 -> next cycle out_valid_o=1 with identical fields, then out_valid_o=0.
- Back-pressure: out_ready_i=0; send A (result 32'h11), B (32'h22), C (32'h33) on consecutive cycles:
  - A and B accepted; in_ready_o=0 after B; C held by source; occupancy_o=2.
  - Release out_ready_i: outputs A, B, C in order, one per cycle, none lost or duplicated.
- Simultaneous accept and pop in ONE: main replaced with new entry; occupancy_o stays 1; in_ready_o stays 1.
- Flush with occupancy 2 plus valid input (mem_write=1): next cycle occupancy_o=0, out_valid_o=0, mem_write_o=0; incoming store never appears.
- x0 suppression: reg_write_i=1, rd_addr_i=0, alu_result_i=32'hDEAD_BEEF -> out_valid_o=1, reg_write_o=0, alu_result_o=32'hDEAD_BEEF.
